// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: 8-way round-robin arbiter with hold limit.
// It routes the data bit of the granted source to a registered output.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no grant; arbitrate on any pending request, from ptr upward
// GRANT | one source holds gnt; release on req drop or hold limit
//
// After every grant there is exactly one IDLE cycle. The pointer then
// advances past the released source, so no requester can starve.
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] D,
  output logic [7:0] gnt,
  output logic [2:0] S,
  output logic       Y,
  output logic       y_valid,
  output logic       busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [3:0] cnt;

  logic [2:0] pick;
  logic [2:0] cand;
  logic       found;
  logic       rel;

  // Search req from ptr upward, wrapping mod 8. The first set bit wins.
  always_comb begin
    pick  = ptr;
    cand  = ptr;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cand = ptr + 3'(k);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // A dropped request and an exhausted hold on the same edge give one release.
  assign rel = !req[S] || (cnt == 4'(MAX_HOLD));

  // Arbitration FSM, output mux and data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= 8'h00;
      S       <= 3'd0;
      Y       <= 1'b0;
      y_valid <= 1'b0;
      busy    <= 1'b0;
      ptr     <= 3'd0;
      cnt     <= 4'd0;
    end else begin
      y_valid <= |gnt;
      if (|gnt)
        Y <= D[S];

      if (state == IDLE) begin
        if (found) begin
          state <= GRANT;
          gnt   <= 8'b1 << pick;
          S     <= pick;
          cnt   <= 4'd1;
          busy  <= 1'b1;
        end else begin
          gnt  <= 8'h00;
          busy <= 1'b0;
        end
      end else begin
        if (rel) begin
          state <= IDLE;
          gnt   <= 8'h00;
          busy  <= 1'b0;
          ptr   <= S + 3'd1;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed testbench for mux8_rr_arbiter with MAX_HOLD = 4.
module tb_mux8_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] D;
  logic [7:0] gnt;
  logic [2:0] S;
  logic       Y;
  logic       y_valid;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  mux8_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .D       (D),
    .gnt     (gnt),
    .S       (S),
    .Y       (Y),
    .y_valid (y_valid),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit for sampling and driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Check every output at the current sample point against expected values.
  task automatic check_all(string tag, logic [7:0] eg, logic [2:0] es,
                           logic ey, logic ev, logic eb);
    n_checks++;
    if (gnt !== eg) begin
      n_fail++;
      $display("FAIL %s gnt: got %h expected %h", tag, gnt, eg);
    end
    n_checks++;
    if (S !== es) begin
      n_fail++;
      $display("FAIL %s S: got %0d expected %0d", tag, S, es);
    end
    n_checks++;
    if (Y !== ey) begin
      n_fail++;
      $display("FAIL %s Y: got %b expected %b", tag, Y, ey);
    end
    n_checks++;
    if (y_valid !== ev) begin
      n_fail++;
      $display("FAIL %s y_valid: got %b expected %b", tag, y_valid, ev);
    end
    n_checks++;
    if (busy !== eb) begin
      n_fail++;
      $display("FAIL %s busy: got %b expected %b", tag, busy, eb);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 8'hFF;
    D   = 8'b10101010;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_all($sformatf("reset_c%0d", i), 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b0;
    req = 8'h00;
  endtask

  task automatic test_single_requester();
    logic [7:0] eg [6] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h01};
    logic       ev [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       eb [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    do_reset();
    D   = 8'b10101010;
    req = 8'b00000001;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_all($sformatf("single_e%0d", i), eg[i], 3'd0, 1'b0, ev[i], eb[i]);
    end
    req = 8'h00;
  endtask

  task automatic test_all_requesters();
    int src, prev_src;
    logic [7:0] eg;
    logic ey, ev, eb;
    do_reset();
    D   = 8'b10101010;
    req = 8'hFF;
    for (int e = 0; e < 45; e++) begin
      tick();
      src      = (e / 5) % 8;
      prev_src = (e == 0) ? 0 : ((e - 1) / 5) % 8;
      eg = ((e % 5) < 4) ? (8'h01 << src) : 8'h00;
      eb = ((e % 5) < 4);
      ev = ((e % 5) != 0);
      ey = (e == 0) ? 1'b0 : prev_src[0];
      check_all($sformatf("all_e%0d", e), eg, 3'(src), ey, ev, eb);
    end
    req = 8'h00;
  endtask

  task automatic test_early_release();
    do_reset();
    D   = 8'b10101010;
    req = 8'b00001000;
    tick();
    check_all("early_g1", 8'h08, 3'd3, 1'b0, 1'b0, 1'b1);
    tick();
    check_all("early_g2", 8'h08, 3'd3, 1'b1, 1'b1, 1'b1);
    req = 8'h00;
    tick();
    check_all("early_rel", 8'h00, 3'd3, 1'b1, 1'b1, 1'b0);
    req = 8'b00011000;
    tick();
    check_all("early_next", 8'h10, 3'd4, 1'b1, 1'b0, 1'b1);
    req = 8'h00;
  endtask

  task automatic test_wrap();
    do_reset();
    D   = 8'b10101010;
    req = 8'b00100000;
    tick();
    check_all("wrap_g5", 8'h20, 3'd5, 1'b0, 1'b0, 1'b1);
    req = 8'b00000001;
    tick();
    check_all("wrap_rel", 8'h00, 3'd5, 1'b1, 1'b1, 1'b0);
    req = 8'b00100001;
    tick();
    check_all("wrap_g0", 8'h01, 3'd0, 1'b1, 1'b0, 1'b1);
    req = 8'h00;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    D   = 8'b10101010;
    req = 8'b00100000;
    tick();
    check_all("midrst_g1", 8'h20, 3'd5, 1'b0, 1'b0, 1'b1);
    req = 8'b00100100;
    tick();
    check_all("midrst_g2", 8'h20, 3'd5, 1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    tick();
    check_all("midrst_rst", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    check_all("midrst_next", 8'h04, 3'd2, 1'b0, 1'b0, 1'b1);
    req = 8'h00;
  endtask

  initial begin
    rst = 1'b1;
    req = 8'h00;
    D   = 8'h00;
    #2;
    test_reset();
    test_single_requester();
    test_all_requesters();
    test_early_release();
    test_wrap();
    test_reset_mid_grant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
